// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top: 4-stage in-order 16-bit pipeline (IF, ID, EX, WB).
//   - 8-bit PC fetching from an internal 256x16 ROM, 16x16 register file.
//   - Operand forwarding in ID from the EX ALU output and from the EX/WB register.
//
// Ports:
//   clk              : rising-edge clock
//   rst              : asynchronous active-high reset of the whole core
//   rst_ALU          : synchronous clear of the ID/EX and EX/WB registers
//   wr_reg_en        : global register-file write enable
//   instr_out        : instruction held in IF/ID
//   wb_enable_wb_in  : EX/WB write flag gated by wr_reg_en
//   wb_result_wb_out : data written to the register file (0 when not writing)
//   alu_result_wb_in : ALU result held in EX/WB
// ---------------------------------------------------------------------------
module top #(
    parameter int ARQ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rst_ALU,
    input  logic           wr_reg_en,
    output logic [ARQ-1:0] instr_out,
    output logic           wb_enable_wb_in,
    output logic [ARQ-1:0] wb_result_wb_out,
    output logic [ARQ-1:0] alu_result_wb_in
);

    // IF stage
    logic [7:0]     pc_q;
    logic [ARQ-1:0] ifid_q;
    logic [ARQ-1:0] rom_data;

    // ID/EX register
    logic [3:0]     ex_op_q;
    logic [3:0]     ex_rd_q;
    logic [ARQ-1:0] ex_a_q;
    logic [ARQ-1:0] ex_b_q;
    logic [ARQ-1:0] ex_c_q;
    logic [7:0]     ex_imm_q;

    // EX/WB register
    logic [ARQ-1:0] wb_res_q;
    logic [3:0]     wb_rd_q;
    logic           wb_flag_q;

    logic [ARQ-1:0] rf_q [16];

    logic [ARQ-1:0] alu_d;
    logic           ex_flag;
    logic           ex_fwd;
    logic [3:0]     src   [3];
    logic [ARQ-1:0] opnd_d [3];

    always_comb begin
        case (pc_q)
            8'd0:    rom_data = 16'h8105;
            8'd1:    rom_data = 16'h8203;
            8'd2:    rom_data = 16'h1312;
            8'd3:    rom_data = 16'h2412;
            8'd4:    rom_data = 16'h5534;
            8'd5:    rom_data = 16'h6634;
            8'd6:    rom_data = 16'h3765;
            default: rom_data = '0;
        endcase
    end

    always_comb begin
        case (ex_op_q)
            4'h1:    alu_d = ex_a_q + ex_b_q;
            4'h2:    alu_d = ex_a_q - ex_b_q;
            4'h3:    alu_d = ex_a_q & ex_b_q;
            4'h4:    alu_d = ex_a_q | ex_b_q;
            4'h5:    alu_d = ex_a_q ^ ex_b_q;
            4'h6:    alu_d = ex_a_q << ex_b_q[3:0];
            4'h7:    alu_d = ex_a_q >> ex_b_q[3:0];
            4'h8:    alu_d = {{(ARQ-8){1'b0}}, ex_imm_q};
            4'h9:    alu_d = ex_c_q + {{(ARQ-8){1'b0}}, ex_imm_q};
            default: alu_d = '0;
        endcase
    end

    assign ex_flag = (ex_op_q >= 4'h1) && (ex_op_q <= 4'h9) && (ex_rd_q != 4'd0);
    assign ex_fwd  = ex_flag && wr_reg_en;

    assign wb_enable_wb_in  = wb_flag_q && wr_reg_en;
    assign wb_result_wb_out = wb_enable_wb_in ? wb_res_q : '0;
    assign alu_result_wb_in = wb_res_q;
    assign instr_out        = ifid_q;

    // Operand sources: 0 = rs1, 1 = rs2, 2 = rd (old value, used by ADDI).
    // r0 is never forwarded because neither write flag can be set for rd == 0.
    always_comb begin
        src[0] = ifid_q[7:4];
        src[1] = ifid_q[3:0];
        src[2] = ifid_q[11:8];
        for (int unsigned i = 0; i < 3; i++) begin
            if (ex_fwd && (ex_rd_q == src[i]))
                opnd_d[i] = alu_d;
            else if (wb_enable_wb_in && (wb_rd_q == src[i]))
                opnd_d[i] = wb_res_q;
            else if (src[i] == 4'd0)
                opnd_d[i] = '0;
            else
                opnd_d[i] = rf_q[src[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ifid_q    <= '0;
            ex_op_q   <= '0;
            ex_rd_q   <= '0;
            ex_a_q    <= '0;
            ex_b_q    <= '0;
            ex_c_q    <= '0;
            ex_imm_q  <= '0;
            wb_res_q  <= '0;
            wb_rd_q   <= '0;
            wb_flag_q <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q   <= pc_q + 8'd1;
            ifid_q <= rom_data;
            if (rst_ALU) begin
                ex_op_q   <= '0;
                ex_rd_q   <= '0;
                ex_a_q    <= '0;
                ex_b_q    <= '0;
                ex_c_q    <= '0;
                ex_imm_q  <= '0;
                wb_res_q  <= '0;
                wb_rd_q   <= '0;
                wb_flag_q <= 1'b0;
            end else begin
                ex_op_q   <= ifid_q[15:12];
                ex_rd_q   <= ifid_q[11:8];
                ex_a_q    <= opnd_d[0];
                ex_b_q    <= opnd_d[1];
                ex_c_q    <= opnd_d[2];
                ex_imm_q  <= ifid_q[7:0];
                wb_res_q  <= alu_d;
                wb_rd_q   <= ex_rd_q;
                wb_flag_q <= ex_flag;
            end
            // The write of the instruction leaving EX/WB still lands when rst_ALU clears the pipe.
            if (wb_enable_wb_in && (wb_rd_q != 4'd0))
                rf_q[wb_rd_q] <= wb_res_q;
        end
    end

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top: self-checking bench for the 4-stage pipeline core.
// An in-order architectural model produces the expected EX/WB value per
// fetched instruction; entries are queued at fetch and popped as they reach
// EX/WB three edges later.
// ---------------------------------------------------------------------------
module tb_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_ALU = 1'b0;
    logic        wr_reg_en = 1'b1;
    logic [15:0] instr_out;
    logic        wb_enable_wb_in;
    logic [15:0] wb_result_wb_out;
    logic [15:0] alu_result_wb_in;

    top #(.ARQ(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rst_ALU          (rst_ALU),
        .wr_reg_en        (wr_reg_en),
        .instr_out        (instr_out),
        .wb_enable_wb_in  (wb_enable_wb_in),
        .wb_result_wb_out (wb_result_wb_out),
        .alu_result_wb_in (alu_result_wb_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        en;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_regs [16];
    int unsigned m_pc;

    logic [15:0] spec_seq [7] = '{16'h0005, 16'h0003, 16'h0008, 16'h0002,
                                  16'h000A, 16'h0020, 16'h0000};

    function automatic logic [15:0] rom_val(input int unsigned a);
        case (a)
            0:       return 16'h8105;
            1:       return 16'h8203;
            2:       return 16'h1312;
            3:       return 16'h2412;
            4:       return 16'h5534;
            5:       return 16'h6634;
            6:       return 16'h3765;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        sb.delete();
        // two bubbles from the cleared IF/ID and ID/EX registers
        sb.push_back('{res: 16'h0, en: 1'b0});
        sb.push_back('{res: 16'h0, en: 1'b0});
    endtask

    task automatic model_issue();
        logic [15:0] ins, a, b, c, r;
        logic [3:0]  op, rd;
        logic        en;
        ins = rom_val(m_pc);
        op  = ins[15:12];
        rd  = ins[11:8];
        a   = m_regs[ins[7:4]];
        b   = m_regs[ins[3:0]];
        c   = m_regs[rd];
        case (op)
            4'h1:    r = a + b;
            4'h2:    r = a - b;
            4'h3:    r = a & b;
            4'h4:    r = a | b;
            4'h5:    r = a ^ b;
            4'h6:    r = a << b[3:0];
            4'h7:    r = a >> b[3:0];
            4'h8:    r = {8'h00, ins[7:0]};
            4'h9:    r = c + {8'h00, ins[7:0]};
            default: r = 16'h0;
        endcase
        en = wr_reg_en && (op >= 4'h1) && (op <= 4'h9) && (rd != 4'd0);
        if (en) m_regs[rd] = r;
        sb.push_back('{res: r, en: en});
        m_pc = (m_pc + 1) % 256;
    endtask

    // One clock: issue the fetched instruction into the model, advance, pop.
    task automatic tick(output exp_t e, output logic [15:0] ei);
        ei = rom_val(m_pc);
        model_issue();
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (instr_out !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", instr_out); end
        n_checks++;
        if (alu_result_wb_in !== 16'h0) begin n_fail++; $display("FAIL reset_alu: got %h want 0000", alu_result_wb_in); end
        n_checks++;
        if (wb_enable_wb_in !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", wb_enable_wb_in); end
        n_checks++;
        if (wb_result_wb_out !== 16'h0) begin n_fail++; $display("FAIL reset_wbres: got %h want 0000", wb_result_wb_out); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_program();
        exp_t        e;
        logic [15:0] ei;
        wr_reg_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            tick(e, ei);
            n_checks++;
            if (instr_out !== ei) begin n_fail++; $display("FAIL prog_instr cyc %0d: got %h want %h", c, instr_out, ei); end
            n_checks++;
            if (alu_result_wb_in !== e.res) begin n_fail++; $display("FAIL prog_alu cyc %0d: got %h want %h", c, alu_result_wb_in, e.res); end
            n_checks++;
            if (wb_enable_wb_in !== e.en) begin n_fail++; $display("FAIL prog_en cyc %0d: got %b want %b", c, wb_enable_wb_in, e.en); end
            n_checks++;
            if (wb_result_wb_out !== (e.en ? e.res : 16'h0)) begin n_fail++; $display("FAIL prog_wbres cyc %0d: got %h", c, wb_result_wb_out); end
            if (c >= 3 && c <= 9) begin
                n_checks++;
                if (alu_result_wb_in !== spec_seq[c-3] || wb_enable_wb_in !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prog_seq cyc %0d: got %h/%b want %h/1", c, alu_result_wb_in, wb_enable_wb_in, spec_seq[c-3]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t        e;
        logic [15:0] ei;
        logic [15:0] first [10];
        wr_reg_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 266; c++) begin
            tick(e, ei);
            if (c >= 3 && c <= 12) first[c-3] = alu_result_wb_in;
            n_checks++;
            if (alu_result_wb_in !== e.res || wb_enable_wb_in !== e.en || instr_out !== ei) begin
                n_fail++;
                $display("FAIL wrap cyc %0d: got %h/%b/%h want %h/%b/%h", c, alu_result_wb_in, wb_enable_wb_in, instr_out, e.res, e.en, ei);
            end
            if (c >= 259 && c <= 265) begin
                n_checks++;
                if (alu_result_wb_in !== spec_seq[c-259] || alu_result_wb_in !== first[c-259]) begin
                    n_fail++;
                    $display("FAIL wrap_pass2 cyc %0d: got %h want %h", c, alu_result_wb_in, spec_seq[c-259]);
                end
            end
        end
    endtask

    task automatic test_no_write();
        exp_t        e;
        logic [15:0] ei;
        wr_reg_en = 1'b0;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick(e, ei);
            n_checks++;
            if (alu_result_wb_in !== e.res) begin n_fail++; $display("FAIL nowr_alu cyc %0d: got %h want %h", c, alu_result_wb_in, e.res); end
            n_checks++;
            if (wb_enable_wb_in !== 1'b0 || wb_result_wb_out !== 16'h0) begin
                n_fail++;
                $display("FAIL nowr_wb cyc %0d: got %b/%h want 0/0000", c, wb_enable_wb_in, wb_result_wb_out);
            end
            if (c == 3 || c == 4 || c == 5) begin
                n_checks++;
                if (alu_result_wb_in !== ((c == 3) ? 16'h5 : (c == 4) ? 16'h3 : 16'h0)) begin
                    n_fail++;
                    $display("FAIL nowr_spec cyc %0d: got %h", c, alu_result_wb_in);
                end
            end
        end
        wr_reg_en = 1'b1;
    endtask

    task automatic test_async_reset();
        exp_t        e;
        logic [15:0] ei;
        wr_reg_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 6; c++) tick(e, ei);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (instr_out !== 16'h0 || alu_result_wb_in !== 16'h0 || wb_enable_wb_in !== 1'b0 || wb_result_wb_out !== 16'h0) begin
            n_fail++;
            $display("FAIL async_rst: got %h/%h/%b/%h want all 0", instr_out, alu_result_wb_in, wb_enable_wb_in, wb_result_wb_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= 11; c++) begin
            tick(e, ei);
            n_checks++;
            if (alu_result_wb_in !== e.res || wb_enable_wb_in !== e.en || instr_out !== ei) begin
                n_fail++;
                $display("FAIL async_rerun cyc %0d: got %h/%b/%h want %h/%b/%h", c, alu_result_wb_in, wb_enable_wb_in, instr_out, e.res, e.en, ei);
            end
            if (c >= 3 && c <= 9) begin
                n_checks++;
                if (alu_result_wb_in !== spec_seq[c-3]) begin n_fail++; $display("FAIL async_seq cyc %0d: got %h want %h", c, alu_result_wb_in, spec_seq[c-3]); end
            end
        end
    endtask

    task automatic test_rst_alu();
        exp_t        e;
        // Edge 4 drops LDI r2 and ADD r3; r1 still lands, so SUB gives 5-0 and later ops see r3 = 0.
        logic [15:0] exp_res [10] = '{16'h0, 16'h0, 16'h5, 16'h0, 16'h0, 16'h5, 16'h5, 16'h0, 16'h0, 16'h0};
        logic        exp_en  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wr_reg_en = 1'b1;
        do_reset();
        sb.delete();
        for (int c = 1; c <= 10; c++) begin
            sb.push_back('{res: exp_res[c-1], en: exp_en[c-1]});
            if (c == 4) rst_ALU = 1'b1;
            @(posedge clk);
            #1;
            rst_ALU = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (alu_result_wb_in !== e.res) begin n_fail++; $display("FAIL rstalu_alu cyc %0d: got %h want %h", c, alu_result_wb_in, e.res); end
            n_checks++;
            if (wb_enable_wb_in !== e.en) begin n_fail++; $display("FAIL rstalu_en cyc %0d: got %b want %b", c, wb_enable_wb_in, e.en); end
            n_checks++;
            if (instr_out !== rom_val(c - 1)) begin n_fail++; $display("FAIL rstalu_instr cyc %0d: got %h want %h", c, instr_out, rom_val(c - 1)); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program();
        test_wrap();
        test_no_write();
        test_async_reset();
        test_rst_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter ARQ, default 16, datapath/instruction width (only 16 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset of the whole core.
REQ-004 SHALL have port rst_ALU  input  1  synchronous active-high clear of ID/EX and EX/WB pipeline registers only.
REQ-005 SHALL have port wr_reg_en  input  1  global register-file write enable.
REQ-006 SHALL have port instr_out  output  16  instruction currently held in the IF/ID register.
REQ-007 SHALL have port wb_enable_wb_in  output  1  write-back enable of the EX/WB stage, gated by wr_reg_en.
REQ-008 SHALL have port wb_result_wb_out  output  16  data written to the register file this cycle; 0 when wb_enable_wb_in=0.
REQ-009 SHALL have port alu_result_wb_in  output  16  ALU result held in the EX/WB register.

Function
REQ-010 SHALL be a 4-stage in-order pipeline IF, ID, EX, WB with 8-bit PC, internal 256x16 instruction ROM, 16x16 register file.
REQ-011 Instruction format SHALL be [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, [7:0] imm8.
REQ-012 Opcodes SHALL be: 0 NOP; 1 ADD rs1+rs2; 2 SUB rs1-rs2; 3 AND; 4 OR; 5 XOR; 6 SHL rs1<<rs2[3:0]; 7 SHR logical rs1>>rs2[3:0]; 8 LDI zero-extended imm8; 9 ADDI rd+imm8 (old rd value); A-F treated as NOP.
REQ-013 Arithmetic SHALL be modulo 2^16, unsigned; no flags.
REQ-014 Each cycle: IF/ID <= ROM[PC], PC <= PC+1, wrapping 255 -> 0; no branches, no stalls.
REQ-015 ID SHALL read rs1, rs2, rd operands; ID/EX holds opcode, rd, operands, imm8.
REQ-016 EX/WB SHALL capture ALU result, rd, and write flag = (opcode in 1-9) and rd != 0.
REQ-017 Register r0 SHALL read as 0 always; writes to r0 ignored.
REQ-018 wb_enable_wb_in SHALL equal EX/WB write flag AND wr_reg_en; register file written at the clock edge when it is 1.
REQ-019 Operand forwarding in ID SHALL select, per operand: EX-stage combinational ALU result if EX rd matches and EX will write (flag AND wr_reg_en); else EX/WB result if WB rd matches and wb_enable_wb_in; else register file.
REQ-020 Instruction at ROM address k SHALL appear on instr_out after edge k+1 and on alu_result_wb_in after edge k+3 (counting edges from reset release).
REQ-021 NOP in EX/WB SHALL give alu_result_wb_in=0, wb_enable_wb_in=0.
REQ-022 ROM contents SHALL be: 0:0x8105, 1:0x8203, 2:0x1312, 3:0x2412, 4:0x5534, 5:0x6634, 6:0x3765, all others 0x0000.
REQ-023 wr_reg_en=0 SHALL block all register writes and EX/WB-sourced forwarding, but not pipeline advance.
REQ-024 rst_ALU=1 SHALL, at the clock edge, zero ID/EX and EX/WB (becoming NOPs) while PC and IF/ID still advance.

Reset
REQ-025 rst=1 SHALL immediately clear PC, IF/ID, ID/EX, EX/WB and all registers to 0; all outputs 0 while rst=1.
REQ-026 rst asserted mid-program SHALL restart execution from address 0 after release.
REQ-027 rst SHALL take priority over rst_ALU and wr_reg_en.

Verification
REQ-028 rst=1 then release, wr_reg_en=1 -> instr_out 0x8105, 0x8203, 0x1312... on edges 1,2,3; alu_result_wb_in 5, 3, 8, 2, 0x000A, 0x0020, 0x0000 after edges 3-9, wb_enable_wb_in=1 for those.
REQ-029 Same run -> back-to-back dependencies (instrs 2-6) produce correct values via forwarding; after edge 10 wb_enable_wb_in=0, outputs 0.
REQ-030 Run 260 cycles -> PC wraps, program re-executes, second pass yields identical result sequence.
REQ-031 wr_reg_en=0 throughout -> wb_enable_wb_in=0, wb_result_wb_out=0, ADD instr yields 0 (operands unwritten); alu_result_wb_in for LDIs still 5, 3.
REQ-032 Assert rst asynchronously mid-cycle at cycle 6 -> all outputs 0 before next edge; after release, sequence of REQ-028 repeats.
REQ-033 Pulse rst_ALU for one edge at edge 4 -> that cycle's EX/WB and ID/EX become NOP (wb_enable_wb_in=0 after edge 4), later instructions continue.
